reverse_job_ctrl: RTL
=====================

// Module: reverse_job_ctrl
// PURPOSE
//  Job sequencer on the enc_clk domain, between the register/AXI interface block and the reverse core.
//  Latches a job descriptor (word count, idle timeout) and pulses the core start.
//  Meters 16-pixel input words from the input buffer to the core, counts bitstream bytes and detects stalls.
//  Returns one done pulse with a status code and byte count, which drives the interface sys_done.
// PARAMETERS
//  LEN_W   16  width of job length, in 16*PIXEL_WIDTH input words
//  TO_W    20  width of idle-timeout counter, in clk cycles
//  BSC_W   32  width of bitstream byte counter
// PORTS
//  clk            in   1      enc_clk; single clock domain
//  rstn           in   1      asynchronous reset, active-low
//  cfg_start_i    in   1      one-cycle job request
//  cfg_len_i      in   LEN_W  input words in job; sampled with cfg_start_i
//  cfg_timeout_i  in   TO_W   idle cycles before abort; 0 = disabled
//  sts_busy_o     out  1      job in progress
//  sts_done_o     out  1      one-cycle job completion pulse (-> interface sys_done_i)
//  sts_err_o      out  2      0 ok, 1 timeout, 2 short (core done before all words read); valid with done, held
//  sts_bs_cnt_o   out  BSC_W  bitstream bytes of last/current job; held until next accepted start
//  core_start_o   out  1      one-cycle start to core (sys_start_i)
//  core_done_i    in   1      core finished (sys_done_o)
//  core_rden_i    in   1      core read request (rden_o)
//  core_rdy_o     out  1      input word available to core this cycle
//  core_bs_val_i  in   1      core bitstream byte strobe (bs_val_o)
//  ibuf_empty_i   in   1      input buffer empty
//  ibuf_rden_o    out  1      input buffer pop
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state IDLE. Reset mid-job aborts silently; no done pulse.
//  FSM IDLE -> LAUNCH -> RUN -> {DONE | ERR} -> IDLE. State is registered; outputs are decoded from state/counters.
//  IDLE: cfg_start_i=1 and cfg_len_i!=0 latches len and timeout, clears rd_cnt, bs_cnt, idle_cnt and sts_err_o -> LAUNCH.
//   cfg_start_i with cfg_len_i==0 -> DONE directly, err=0, bs_cnt=0; core_start_o is never raised.
//  LAUNCH: core_start_o=1 for exactly one cycle, sts_busy_o=1 -> RUN. Start appears 1 cycle after cfg_start_i.
//  RUN: core_rdy_o = ~ibuf_empty_i & (rd_cnt < len). ibuf_rden_o = core_rden_i & core_rdy_o.
//   rd_cnt++ on ibuf_rden_o. core_rden_i while core_rdy_o=0 is ignored (no pop, no count).
//   bs_cnt++ on core_bs_val_i, saturating at 2^BSC_W-1.
//   idle_cnt clears on any ibuf_rden_o or core_bs_val_i, otherwise increments.
//   idle_cnt == timeout-1 with timeout!=0 -> ERR (err=1).
//   core_done_i -> DONE; err=2 if rd_cnt < len, else 0. core_done_i and timeout in the same cycle: done wins.
//  DONE/ERR: sts_done_o=1 for one cycle, sts_busy_o=0 next cycle -> IDLE. Done pulse lands 1 cycle after core_done_i.
//   The core is not reset on ERR. A later stray core_done_i is ignored.
//  cfg_start_i outside IDLE is ignored (no queueing).
//  core_done_i, core_bs_val_i and core_rden_i outside RUN are ignored; core_rdy_o and ibuf_rden_o are 0 outside RUN.
//  sts_busy_o = 1 in LAUNCH and RUN.
// STRUCTURE
//  Shared package/defines (enc_defines.v): state encodings, REV_ERR_OK/TIMEOUT/SHORT codes.
//  Sub-module reverse_idle_timer: clear/enable/limit inputs, expire output, TO_W counter.
//  Everything else is inline in reverse_job_ctrl.
// TESTING
//  1 Nominal: len=4, timeout=100, buffer never empty, core reads 4 words, 10 bs_val, then done
//    -> core_start at cycle+1, 4 pops, done pulse with err=0, bs_cnt=10.
//  2 Empty buffer: len=2, ibuf_empty_i=1 for 5 cycles while core_rden_i=1
//    -> core_rdy_o=0 and no pops until non-empty, then exactly 2 pops.
//  3 Timeout: timeout=8, no core activity -> ERR 8 cycles into RUN, done pulse with err=1; stray core_done_i later ignored.
//  4 Short and overrun: len=3, core done after 2 words -> err=2. Separate run, len=3 with core_rden_i held 6 cycles -> exactly 3 pops.
//  5 Edges: cfg_len_i=0 -> done pulse with err=0 and no core_start. cfg_start_i during RUN -> ignored.
//    core_done_i and timeout expire in the same cycle -> err=0.
//  6 Reset mid-RUN: rstn low for 1 cycle -> all outputs 0, no done pulse; next job runs normally.

Source files
------------

// File: rtl/reverse_job_ctrl_pkg.sv
// Shared types for the reverse job sequencer: FSM state encoding and completion status codes.
package reverse_job_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REV_ERR_OK      = 2'd0,
    REV_ERR_TIMEOUT = 2'd1,
    REV_ERR_SHORT   = 2'd2
  } rev_err_e;

endpackage

// File: rtl/reverse_job_ctrl_idle_timer.sv
// Idle-cycle counter: clears on activity, counts while enabled, flags the cycle it reaches limit-1.
// A zero limit disables expiry; the count simply wraps and is never observed.
module reverse_job_ctrl_idle_timer #(
  parameter int TO_W = 20
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (limit_i != '0) && (cnt_q == limit_i - TO_W'(1));

endmodule

// File: rtl/reverse_job_ctrl.sv
// Job sequencer between the register interface and the reverse core: launches a job, meters input
// words, counts bitstream bytes, detects idle stalls and reports one done pulse with a status code.
module reverse_job_ctrl
  import reverse_job_ctrl_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int TO_W  = 20,
  parameter int BSC_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [TO_W-1:0]  cfg_timeout_i,
  output logic             sts_busy_o,
  output logic             sts_done_o,
  output logic [1:0]       sts_err_o,
  output logic [BSC_W-1:0] sts_bs_cnt_o,
  output logic             core_start_o,
  input  logic             core_done_i,
  input  logic             core_rden_i,
  output logic             core_rdy_o,
  input  logic             core_bs_val_i,
  input  logic             ibuf_empty_i,
  output logic             ibuf_rden_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [BSC_W-1:0] bs_cnt_q, bs_cnt_d;
  rev_err_e         err_q, err_d;

  logic in_run, pop, bs_strb, idle_clr, to_expire;

  assign in_run  = (state_q == ST_RUN);
  assign core_rdy_o  = in_run && !ibuf_empty_i && (rd_cnt_q < len_q);
  assign pop         = core_rdy_o && core_rden_i;
  assign ibuf_rden_o = pop;
  assign bs_strb     = in_run && core_bs_val_i;
  // Outside RUN the timer is held at zero so each job starts its idle window fresh.
  assign idle_clr    = !in_run || pop || bs_strb;

  reverse_job_ctrl_idle_timer #(.TO_W(TO_W)) u_idle_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (idle_clr),
    .en_i     (in_run),
    .limit_i  (to_q),
    .expire_o (to_expire)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    to_d     = to_q;
    bs_cnt_d = bs_cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          rd_cnt_d = '0;
          bs_cnt_d = '0;
          err_d    = REV_ERR_OK;
          if (cfg_len_i != '0) begin
            len_d   = cfg_len_i;
            to_d    = cfg_timeout_i;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (pop) begin
          rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end
        if (bs_strb && (bs_cnt_q != '1)) begin
          bs_cnt_d = bs_cnt_q + BSC_W'(1);
        end
        // A word popped in the same cycle as core done still counts toward completeness.
        if (core_done_i) begin
          state_d = ST_DONE;
          err_d   = (rd_cnt_d < len_q) ? REV_ERR_SHORT : REV_ERR_OK;
        end else if (to_expire) begin
          state_d = ST_ERR;
          err_d   = REV_ERR_TIMEOUT;
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      to_q     <= '0;
      bs_cnt_q <= '0;
      err_q    <= REV_ERR_OK;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      to_q     <= to_d;
      bs_cnt_q <= bs_cnt_d;
      err_q    <= err_d;
    end
  end

  assign sts_busy_o   = (state_q == ST_LAUNCH) || in_run;
  assign sts_done_o   = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign core_start_o = (state_q == ST_LAUNCH);
  assign sts_err_o    = err_q;
  assign sts_bs_cnt_o = bs_cnt_q;

endmodule
